pr_stage_skid: RTL and testbench
================================

Name: pr_stage_skid

Overview:
- Generic, parametrised pipeline-stage register for the CPU core pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces fixed-field, always-advance stage registers with a valid/ready handshake, a 2-entry skid buffer (IN_READY is registered), synchronous flush, and bubble insertion.
- Splits the payload into a data field (never cleared) and a control field (forced to a bubble value when invalid or flushed).
- Instantiated once per stage boundary; hazard/branch logic drives FLUSH and OUT_READY.

Parameters:
- DATA_W, 128, width of the data payload (PC, operands, immediates, addresses).
- CTRL_W, 32, width of the control payload (write enables, mem read/write, branch ctrl, selects).
- CTRL_BUBBLE, {CTRL_W{1'b0}}, control value presented whenever the stage holds no valid instruction.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  upstream holds a valid instruction.
- IN_READY  out  1  stage can accept; registered, no combinational path from OUT_READY.
- IN_DATA  in  DATA_W  upstream data payload.
- IN_CTRL  in  CTRL_W  upstream control payload.
- OUT_VALID  out  1  stage presents a valid instruction.
- OUT_READY  in  1  downstream accepts (0 = stall).
- OUT_DATA  out  DATA_W  data payload of the head entry.
- OUT_CTRL  out  CTRL_W  control of the head entry; CTRL_BUBBLE when OUT_VALID=0.
- FLUSH  in  1  synchronous kill of all held and incoming entries.
- OCCUPANCY  out  2  entries held (0, 1, 2).
- STALL_CNT  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (async, RESET_N=0):
  - State=EMPTY.
  - OUT_VALID=0, IN_READY=1, OUT_DATA=0, OUT_CTRL=CTRL_BUBBLE.
  - OCCUPANCY=0, STALL_CNT=0, skid entry cleared.
  - Deassertion takes effect at the next CLK edge.
- Transfer rules:
  - push = IN_VALID & IN_READY.
  - pop = OUT_VALID & OUT_READY.
  - Both are evaluated at the rising edge.
- Latency: a pushed entry appears on OUT_* the cycle after the push when the stage was EMPTY, or when it was MAIN with a same-cycle pop. Order is strictly FIFO.
- States (OCCUPANCY = 0/1/2):
  - EMPTY: push -> MAIN (main <= IN).
  - MAIN:
    - push & pop -> MAIN (main <= IN).
    - push & !pop -> FULL (skid <= IN; IN_READY <= 0).
    - !push & pop -> EMPTY.
    - otherwise hold.
  - FULL (IN_READY=0, push impossible):
    - pop -> MAIN (main <= skid; IN_READY <= 1).
    - otherwise hold.
- Stall hold: when OUT_VALID=1 and OUT_READY=0, OUT_DATA and OUT_CTRL stay bit-stable.
- OUT_CTRL = main_ctrl when OUT_VALID=1, else CTRL_BUBBLE. OUT_DATA keeps its last value while invalid.
- FLUSH=1 (overrides push/pop):
  - Next state is EMPTY, IN_READY <= 1, OUT_CTRL -> CTRL_BUBBLE.
  - An input presented during the flush cycle is discarded.
  - Data registers are not cleared.
  - Flush in FULL discards both entries.
- STALL_CNT:
  - +1 each cycle with OUT_VALID & !OUT_READY & !FLUSH.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset.
- IN_READY is the register output !skid_valid; OUT_READY has no combinational path to IN_READY.
- FULL is reachable only by a push while main is held.
- Simultaneous push & pop in FULL cannot occur (IN_READY=0).

Decomposition:
- Shared package pr_pkg:
  - State encoding localparams (PR_EMPTY=2'd0, PR_MAIN=2'd1, PR_FULL=2'd2).
  - Default control bubble constant.
  - Per-stage DATA_W/CTRL_W constants (PR_ID_EX_DATA_W etc.) so all stages use one source.
- One sub-module, pr_slot: a single valid+data+ctrl storage entry with load enable, async clear and bubble masking. It is instantiated twice (main, skid).
- The FSM and stall counter stay in pr_stage_skid.

Test Plan:
- Reset mid-operation: fill to FULL, pulse RESET_N=0 without CLK -> OUT_VALID=0, OUT_CTRL=CTRL_BUBBLE, IN_READY=1, OCCUPANCY=0, STALL_CNT=0 immediately.
- Streaming: OUT_READY=1, push A=0x11, B=0x22, C=0x33 on consecutive cycles -> OUT_DATA 0x11, 0x22, 0x33 one cycle later each; OCCUPANCY stays 1; IN_READY stays 1.
- Backpressure/skid: OUT_READY=0, push A then B -> OCCUPANCY=2, IN_READY=0, OUT_DATA=A stable. Raise OUT_READY for 2 cycles -> A then B pop in order, IN_READY=1 after the first pop. STALL_CNT increments once per stalled cycle.
- Flush: FULL with A,B and FLUSH=1 with IN_VALID=1 carrying C -> next cycle OUT_VALID=0, OUT_CTRL=CTRL_BUBBLE, OCCUPANCY=0, C never appears on OUT.
- Saturation: CNT_W=4, OUT_VALID=1, OUT_READY=0 for 20 cycles -> STALL_CNT=15, holds at 15.
- Random: constrained-random IN_VALID/OUT_READY/FLUSH (5%) for 10k cycles against a scoreboard FIFO model -> no loss, duplication or reordering. OUT_CTRL=CTRL_BUBBLE whenever OUT_VALID=0.

Source files
------------

// File: rtl/pr_pkg.sv
// Shared definitions for the pipeline-stage skid registers: state encoding, bubble
// constant and per-stage payload widths so every stage boundary sizes from one place.
package pr_pkg;

  localparam logic [1:0] PR_EMPTY = 2'd0;
  localparam logic [1:0] PR_MAIN  = 2'd1;
  localparam logic [1:0] PR_FULL  = 2'd2;

  // Encoding equals the number of held entries, so state doubles as occupancy.
  typedef enum logic [1:0] {
    StEmpty = PR_EMPTY,
    StMain  = PR_MAIN,
    StFull  = PR_FULL
  } pr_state_e;

  localparam int unsigned PR_DATA_W_DEFAULT = 128;
  localparam int unsigned PR_CTRL_W_DEFAULT = 32;
  localparam int unsigned PR_CNT_W_DEFAULT  = 16;

  localparam logic [PR_CTRL_W_DEFAULT-1:0] PR_CTRL_BUBBLE = '0;

  localparam int unsigned PR_IF_ID_DATA_W  = 96;
  localparam int unsigned PR_IF_ID_CTRL_W  = 8;
  localparam int unsigned PR_ID_EX_DATA_W  = 128;
  localparam int unsigned PR_ID_EX_CTRL_W  = 32;
  localparam int unsigned PR_EX_MEM_DATA_W = 128;
  localparam int unsigned PR_EX_MEM_CTRL_W = 16;
  localparam int unsigned PR_MEM_WB_DATA_W = 64;
  localparam int unsigned PR_MEM_WB_CTRL_W = 8;

endpackage : pr_pkg

// File: rtl/pr_slot.sv
// Single storage entry of a pipeline stage: valid flag, data and control payloads,
// with load, clear of the valid flag and bubble masking of the control output.
module pr_slot #(
  parameter int unsigned          DATA_W      = 128,
  parameter int unsigned          CTRL_W      = 32,
  parameter logic [CTRL_W-1:0]    CTRL_BUBBLE = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  // Clear only drops the valid flag; payloads are left untouched.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      ctrl_d  = ctrl_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= CTRL_BUBBLE;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = valid_q ? ctrl_q : CTRL_BUBBLE;

endmodule : pr_slot

// File: rtl/pr_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer, synchronous
// flush, bubble insertion on the control payload and a saturating stall counter.
module pr_stage_skid
  import pr_pkg::*;
#(
  parameter int unsigned       DATA_W      = PR_DATA_W_DEFAULT,
  parameter int unsigned       CTRL_W      = PR_CTRL_W_DEFAULT,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int unsigned       CNT_W       = PR_CNT_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  input  logic              flush_i,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  pr_state_e         state_q, state_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              push, pop;
  logic              main_load, main_clr, main_from_skid;
  logic              skid_load, skid_clr;
  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data, main_data_in;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;

  // in_ready is a pure register output, so out_ready never reaches it combinationally.
  assign in_ready_o = ~skid_valid;
  assign push       = in_valid_i & in_ready_o;
  assign pop        = main_valid & out_ready_i;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush_i) begin
      state_d  = StEmpty;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (push) begin
            main_load = 1'b1;
            state_d   = StMain;
          end
        end
        StMain: begin
          if (push && pop) begin
            main_load = 1'b1;
          end else if (push) begin
            skid_load = 1'b1;
            state_d   = StFull;
          end else if (pop) begin
            main_clr = 1'b1;
            state_d  = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = StMain;
          end
        end
        default: begin
          state_d  = StEmpty;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign main_data_in = main_from_skid ? skid_data : in_data_i;
  assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl_i;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid && !out_ready_i && !flush_i && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StEmpty;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  pr_slot #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .CTRL_BUBBLE (CTRL_BUBBLE)
  ) u_main (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (main_load),
    .clr_i   (main_clr),
    .data_i  (main_data_in),
    .ctrl_i  (main_ctrl_in),
    .valid_o (main_valid),
    .data_o  (main_data),
    .ctrl_o  (main_ctrl)
  );

  pr_slot #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .CTRL_BUBBLE (CTRL_BUBBLE)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (skid_load),
    .clr_i   (skid_clr),
    .data_i  (in_data_i),
    .ctrl_i  (in_ctrl_i),
    .valid_o (skid_valid),
    .data_o  (skid_data),
    .ctrl_o  (skid_ctrl)
  );

  assign out_valid_o = main_valid;
  assign out_data_o  = main_data;
  assign out_ctrl_o  = main_ctrl;
  assign occupancy_o = state_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule : pr_stage_skid

// File: tb/tb_pr_stage_skid.sv
// Directed plus random bench for pr_stage_skid, checked against a queue-based model.
module tb_pr_stage_skid;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;
  localparam int unsigned NW = 4;
  localparam logic [CW-1:0] BUB = 8'hA5;
  localparam int SAT = 15;

  logic          clk;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, flush;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [1:0]    occ;
  logic [NW-1:0] stall;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t          mq[$];
  logic [DW-1:0] m_last;
  int            m_cnt;
  int            checks;
  int            errors;

  pr_stage_skid #(
    .DATA_W      (DW),
    .CTRL_W      (CW),
    .CTRL_BUBBLE (BUB),
    .CNT_W       (NW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_ctrl_i   (in_ctrl),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_ctrl_o  (out_ctrl),
    .flush_i     (flush),
    .occupancy_o (occ),
    .stall_cnt_o (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] e_data;
    logic [31:0] e_ctrl;
    e_data = 32'(m_last);
    e_ctrl = 32'(BUB);
    if (mq.size() > 0) begin
      e_data = 32'(mq[0].d);
      e_ctrl = 32'(mq[0].c);
    end
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    chk("occupancy", 32'(occ), 32'(mq.size()));
    chk("out_data", 32'(out_data), e_data);
    chk("out_ctrl", 32'(out_ctrl), e_ctrl);
    chk("stall_cnt", 32'(stall), 32'(m_cnt));
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = '0;
    m_cnt  = 0;
  endtask

  // Advance one clock: update the model from the current inputs, then compare.
  task automatic step();
    bit   push;
    bit   pop;
    ent_t e;
    push = in_valid && (mq.size() < 2);
    pop  = (mq.size() > 0) && out_ready;
    if ((mq.size() > 0) && !out_ready && !flush && (m_cnt < SAT)) m_cnt++;
    if (flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.d = in_data;
        e.c = in_ctrl;
        mq.push_back(e);
      end
    end
    if (mq.size() > 0) m_last = mq[0].d;
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = r;
    flush     = f;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #12;
    check_model();
    chk("rst_ctrl", 32'(out_ctrl), 32'(BUB));
    rst_n = 1'b1;

    // Streaming with downstream always ready
    drive(1'b1, 16'h0011, 8'h01, 1'b1, 1'b0);
    step();
    chk("stream_a", 32'(out_data), 32'h11);
    drive(1'b1, 16'h0022, 8'h02, 1'b1, 1'b0);
    step();
    chk("stream_b", 32'(out_data), 32'h22);
    drive(1'b1, 16'h0033, 8'h03, 1'b1, 1'b0);
    step();
    chk("stream_c", 32'(out_data), 32'h33);
    chk("stream_occ", 32'(occ), 32'd1);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();

    // Backpressure into the skid entry
    drive(1'b1, 16'h00A1, 8'h11, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h00B2, 8'h22, 1'b0, 1'b0);
    step();
    chk("skid_occ", 32'(occ), 32'd2);
    chk("skid_ready", 32'(in_ready), 32'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    step();
    chk("skid_hold", 32'(out_data), 32'hA1);
    chk("skid_stall", 32'(stall), 32'd2);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    chk("pop_a_next_b", 32'(out_data), 32'hB2);
    chk("pop_ready", 32'(in_ready), 32'd1);
    step();
    chk("pop_b_empty", 32'(out_valid), 32'd0);

    // Flush while full with a new input present
    drive(1'b1, 16'h0A0A, 8'h31, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h0B0B, 8'h32, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h0C0C, 8'h33, 1'b0, 1'b1);
    step();
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ctrl", 32'(out_ctrl), 32'(BUB));
    chk("flush_occ", 32'(occ), 32'd0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step();

    // Stall counter saturation
    drive(1'b1, 16'h5555, 8'h44, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt", 32'(stall), 32'd15);
    step();
    chk("sat_hold", 32'(stall), 32'd15);

    // Asynchronous reset while full, no clock edge
    drive(1'b1, 16'h6666, 8'h55, 1'b0, 1'b0);
    step();
    chk("pre_rst_occ", 32'(occ), 32'd2);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ctrl", 32'(out_ctrl), 32'(BUB));
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_occ", 32'(occ), 32'd0);
    chk("arst_cnt", 32'(stall), 32'd0);
    check_model();
    #2;
    rst_n = 1'b1;

    // Random traffic against the queue model
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 99) < 70), 16'($urandom), 8'($urandom),
            1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 5));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pr_stage_skid
